// File: rtl/turf_event_frag_tx.sv
// Purpose: splits TURF events into UDP fragments. Each fragment is a UDP header, one tag qword, then up to nfragment+1 payload qwords.
// Latency: the UDP header is valid 2 cycles after the descriptor handshake. Payload passes through combinationally.
// Backpressure: an m_ tready stall holds the FSM indefinitely. While forwarding payload, s_evdata_tready follows m_udpdata_tready.
// Ports: s_evhdr_* event descriptor {addr, len}; s_evdata_* payload stream; m_udphdr_* {ip, port, udp_len};
//        m_udpdata_* fragment stream; event_* / nfragment_count_i are destination controls sampled per event;
//        dropped_count_o counts closed-destination events (saturating); err_len_o flags tlast/length disagreement.
module turf_event_frag_tx #(
    parameter int LEN_BITS      = 20,
    parameter int ADDR_BITS     = 12,
    parameter int DROP_CNT_BITS = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [31:0]              s_evhdr_tdata,
    input  logic                     s_evhdr_tvalid,
    output logic                     s_evhdr_tready,
    input  logic [63:0]              s_evdata_tdata,
    input  logic                     s_evdata_tvalid,
    output logic                     s_evdata_tready,
    input  logic                     s_evdata_tlast,
    output logic [63:0]              m_udphdr_tdata,
    output logic                     m_udphdr_tvalid,
    input  logic                     m_udphdr_tready,
    output logic [63:0]              m_udpdata_tdata,
    output logic [7:0]               m_udpdata_tkeep,
    output logic                     m_udpdata_tvalid,
    input  logic                     m_udpdata_tready,
    output logic                     m_udpdata_tlast,
    input  logic [9:0]               nfragment_count_i,
    input  logic [31:0]              event_ip_i,
    input  logic [15:0]              event_port_i,
    input  logic                     event_open_i,
    output logic [DROP_CNT_BITS-1:0] dropped_count_o,
    output logic                     err_len_o
);

    // One extra bit so that a zero-length descriptor can hold 2^LEN_BITS qwords.
    localparam int REM_W = LEN_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FRAG_HDR,
        S_FRAG_TAG,
        S_FRAG_DATA,
        S_NEXT,
        S_DROP
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDR_BITS-1:0]     r_addr;
    logic [REM_W-1:0]         r_rem_ev;
    logic [10:0]              r_frag_len;
    logic [10:0]              r_frag_rem;
    logic [10:0]              r_n;
    logic                     r_last;
    logic [15:0]              r_frag_idx;
    logic [31:0]              r_ip;
    logic [15:0]              r_port;
    logic                     r_open;
    logic [DROP_CNT_BITS-1:0] r_drop_cnt;
    logic                     r_err_len;

    logic [LEN_BITS-1:0]      w_hdr_len;
    logic [ADDR_BITS-1:0]     w_hdr_addr;
    logic                     w_last;
    logic [10:0]              w_n;
    logic [15:0]              w_nbytes;
    logic [15:0]              w_udp_len;
    logic [11:0]              w_addr12;
    logic [63:0]              w_tag;
    logic                     w_rem_is_one;
    logic                     w_beat;

    logic                     w_evhdr_rdy;
    logic                     w_evdata_rdy;
    logic                     w_udphdr_vld;
    logic                     w_udpdata_vld;
    logic                     w_udpdata_last;
    logic [63:0]              w_udpdata_dat;

    assign w_hdr_len    = s_evhdr_tdata[LEN_BITS-1:0];
    assign w_hdr_addr   = s_evhdr_tdata[LEN_BITS +: ADDR_BITS];

    // Size of the next fragment: whatever is left of the event, capped at the fragment length.
    assign w_last       = (r_rem_ev <= REM_W'(r_frag_len));
    assign w_n          = w_last ? r_rem_ev[10:0] : r_frag_len;

    assign w_nbytes     = {2'b00, r_n, 3'b000};
    assign w_udp_len    = 16'd16 + w_nbytes;
    assign w_addr12     = 12'(r_addr);
    assign w_tag        = {4'h0, w_addr12, r_frag_idx, w_nbytes, 15'h0, r_last};
    assign w_rem_is_one = (r_rem_ev == REM_W'(1));
    assign w_beat       = s_evdata_tvalid && w_evdata_rdy;

    always_comb begin
        w_state_nxt    = r_state;
        w_evhdr_rdy    = 1'b0;
        w_evdata_rdy   = 1'b0;
        w_udphdr_vld   = 1'b0;
        w_udpdata_vld  = 1'b0;
        w_udpdata_last = 1'b0;
        w_udpdata_dat  = s_evdata_tdata;
        case (r_state)
            S_IDLE: begin
                w_evhdr_rdy = 1'b1;
                if (s_evhdr_tvalid) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = r_open ? S_FRAG_HDR : S_DROP;
            end
            S_FRAG_HDR: begin
                w_udphdr_vld = 1'b1;
                if (m_udphdr_tready) w_state_nxt = S_FRAG_TAG;
            end
            S_FRAG_TAG: begin
                w_udpdata_vld = 1'b1;
                w_udpdata_dat = w_tag;
                if (m_udpdata_tready) w_state_nxt = S_FRAG_DATA;
            end
            S_FRAG_DATA: begin
                w_udpdata_vld  = s_evdata_tvalid;
                w_evdata_rdy   = m_udpdata_tready;
                w_udpdata_last = (r_frag_rem == 11'd1);
                if (w_beat && (r_frag_rem == 11'd1)) begin
                    w_state_nxt = (r_rem_ev > REM_W'(1)) ? S_NEXT : S_IDLE;
                end
            end
            S_NEXT: begin
                w_state_nxt = S_FRAG_HDR;
            end
            S_DROP: begin
                w_evdata_rdy = 1'b1;
                if (s_evdata_tvalid && w_rem_is_one) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_rem_ev   <= '0;
            r_frag_len <= '0;
            r_frag_rem <= '0;
            r_n        <= '0;
            r_last     <= 1'b0;
            r_frag_idx <= '0;
            r_ip       <= '0;
            r_port     <= '0;
            r_open     <= 1'b0;
            r_drop_cnt <= '0;
            r_err_len  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_err_len <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (s_evhdr_tvalid) begin
                        r_addr     <= w_hdr_addr;
                        r_rem_ev   <= (w_hdr_len == '0) ? (REM_W'(1) << LEN_BITS)
                                                        : REM_W'(w_hdr_len);
                        r_frag_len <= 11'(nfragment_count_i) + 11'd1;
                        r_ip       <= event_ip_i;
                        r_port     <= event_port_i;
                        r_open     <= event_open_i;
                        r_frag_idx <= '0;
                    end
                end
                S_LOAD: begin
                    r_n        <= w_n;
                    r_last     <= w_last;
                    r_frag_rem <= w_n;
                    if (!r_open && (r_drop_cnt != '1)) begin
                        r_drop_cnt <= r_drop_cnt + DROP_CNT_BITS'(1);
                    end
                end
                S_NEXT: begin
                    r_n        <= w_n;
                    r_last     <= w_last;
                    r_frag_rem <= w_n;
                    r_frag_idx <= r_frag_idx + 16'd1;
                end
                S_FRAG_DATA: begin
                    if (w_beat) begin
                        r_frag_rem <= r_frag_rem - 11'd1;
                        r_rem_ev   <= r_rem_ev - REM_W'(1);
                        r_err_len  <= (s_evdata_tlast != w_rem_is_one);
                    end
                end
                S_DROP: begin
                    if (s_evdata_tvalid) begin
                        r_rem_ev  <= r_rem_ev - REM_W'(1);
                        r_err_len <= (s_evdata_tlast != w_rem_is_one);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are held low while reset is asserted, even though the state register already reads IDLE.
    assign s_evhdr_tready   = w_evhdr_rdy   && !areset;
    assign s_evdata_tready  = w_evdata_rdy  && !areset;
    assign m_udphdr_tvalid  = w_udphdr_vld  && !areset;
    assign m_udpdata_tvalid = w_udpdata_vld && !areset;
    assign m_udphdr_tdata   = {r_ip, r_port, w_udp_len};
    assign m_udpdata_tdata  = w_udpdata_dat;
    assign m_udpdata_tlast  = w_udpdata_last;
    assign m_udpdata_tkeep  = 8'hFF;
    assign dropped_count_o  = r_drop_cnt;
    assign err_len_o        = r_err_len;

endmodule

// File: tb/tb_turf_event_frag_tx.sv
// Purpose: testbench for turf_event_frag_tx. A fragment model builds the expected UDP headers and data beats for each event.
// Latency: inputs are driven 1 time unit after the rising edge, and outputs are observed on the falling edge.
// Backpressure: when stalls are enabled, the bench randomly drops m_ tready and inserts gaps in s_evdata tvalid.
module tb_turf_event_frag_tx;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_evhdr_tdata = '0;
    logic        s_evhdr_tvalid = 1'b0;
    logic        s_evhdr_tready;
    logic [63:0] s_evdata_tdata = '0;
    logic        s_evdata_tvalid = 1'b0;
    logic        s_evdata_tready;
    logic        s_evdata_tlast = 1'b0;
    logic [63:0] m_udphdr_tdata;
    logic        m_udphdr_tvalid;
    logic        m_udphdr_tready = 1'b0;
    logic [63:0] m_udpdata_tdata;
    logic [7:0]  m_udpdata_tkeep;
    logic        m_udpdata_tvalid;
    logic        m_udpdata_tready = 1'b0;
    logic        m_udpdata_tlast;
    logic [9:0]  nfragment_count_i = '0;
    logic [31:0] event_ip_i = '0;
    logic [15:0] event_port_i = '0;
    logic        event_open_i = 1'b0;
    logic [15:0] dropped_count_o;
    logic        err_len_o;

    turf_event_frag_tx dut (
        .aclk(aclk), .areset(areset),
        .s_evhdr_tdata(s_evhdr_tdata), .s_evhdr_tvalid(s_evhdr_tvalid), .s_evhdr_tready(s_evhdr_tready),
        .s_evdata_tdata(s_evdata_tdata), .s_evdata_tvalid(s_evdata_tvalid),
        .s_evdata_tready(s_evdata_tready), .s_evdata_tlast(s_evdata_tlast),
        .m_udphdr_tdata(m_udphdr_tdata), .m_udphdr_tvalid(m_udphdr_tvalid), .m_udphdr_tready(m_udphdr_tready),
        .m_udpdata_tdata(m_udpdata_tdata), .m_udpdata_tkeep(m_udpdata_tkeep),
        .m_udpdata_tvalid(m_udpdata_tvalid), .m_udpdata_tready(m_udpdata_tready),
        .m_udpdata_tlast(m_udpdata_tlast),
        .nfragment_count_i(nfragment_count_i), .event_ip_i(event_ip_i),
        .event_port_i(event_port_i), .event_open_i(event_open_i),
        .dropped_count_o(dropped_count_o), .err_len_o(err_len_o)
    );

    always #5 aclk = ~aclk;

    int          n_cmp = 0;
    int          n_mis = 0;
    bit          stall_en = 1'b0;
    logic [63:0] obs_hdr[$];
    logic [63:0] exp_hdr[$];
    logic [64:0] obs_dat[$];
    logic [64:0] exp_dat[$];
    int          obs_err[$];
    int          in_beats = 0;
    int          exp_drop = 0;

    // The downstream side randomly drops tready when stalls are enabled.
    initial forever begin
        @(posedge aclk);
        #1;
        m_udphdr_tready  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_udpdata_tready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // The monitor records handshakes. It also records which consumed input beat each err_len_o pulse follows.
    initial forever begin
        @(negedge aclk);
        if (!areset) begin
            if (err_len_o) obs_err.push_back(in_beats);
            if (m_udphdr_tvalid && m_udphdr_tready) obs_hdr.push_back(m_udphdr_tdata);
            if (m_udpdata_tvalid && m_udpdata_tready) obs_dat.push_back({m_udpdata_tlast, m_udpdata_tdata});
            if (s_evdata_tvalid && s_evdata_tready) in_beats++;
        end
    end

    task automatic clear_all();
        obs_hdr.delete(); exp_hdr.delete(); obs_dat.delete(); exp_dat.delete();
        obs_err.delete(); in_beats = 0;
    endtask

    // Reference model: an event is cut into chunks of at most nf+1 qwords. Each chunk becomes a header, a tag and its payload.
    task automatic model_event(input int len, input logic [11:0] addr, input int nf,
                               input logic [31:0] ip, input logic [15:0] port,
                               input bit open, input logic [31:0] seed);
        int rem, idx, pos, fl, n;
        if (!open) begin
            if (exp_drop < 65535) exp_drop++;
            return;
        end
        rem = len; idx = 0; pos = 0; fl = nf + 1;
        while (rem > 0) begin
            n = (rem < fl) ? rem : fl;
            exp_hdr.push_back({ip, port, 16'(16 + 8 * n)});
            exp_dat.push_back({1'b0, 4'h0, addr, 16'(idx), 16'(8 * n), 15'h0, (rem <= fl)});
            for (int k = 0; k < n; k++) begin
                exp_dat.push_back({(k == n - 1), seed, 32'(pos)});
                pos++;
            end
            rem -= n;
            idx++;
        end
    endtask

    task automatic send_hdr(input int len, input logic [11:0] addr, output bit ok);
        s_evhdr_tdata  = {addr, 20'(len)};
        s_evhdr_tvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge aclk);
            if (s_evhdr_tready) begin ok = 1'b1; break; end
        end
        @(posedge aclk);
        #1;
        s_evhdr_tvalid = 1'b0;
        if (!ok) begin
            n_cmp++; n_mis++;
            $display("FAIL evhdr_timeout: tready never seen, need handshake within 2000 cycles");
        end
    endtask

    task automatic send_data(input int len, input logic [31:0] seed, input int tlast_at, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < len && ok; i++) begin
            if (stall_en) begin
                repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
            end
            s_evdata_tvalid = 1'b1;
            s_evdata_tdata  = {seed, 32'(i)};
            s_evdata_tlast  = (i + 1 == tlast_at);
            ok = 1'b0;
            for (int c = 0; c < 2000; c++) begin
                @(negedge aclk);
                if (s_evdata_tready) begin ok = 1'b1; break; end
            end
            @(posedge aclk);
            #1;
            s_evdata_tvalid = 1'b0;
            s_evdata_tlast  = 1'b0;
        end
        if (!ok) begin
            n_cmp++; n_mis++;
            $display("FAIL evdata_timeout: beat not accepted, need acceptance within 2000 cycles");
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_cmp++;
        if ({s_evhdr_tready, s_evdata_tready, m_udphdr_tvalid, m_udpdata_tvalid, err_len_o} !== 5'b0) begin
            n_mis++;
            $display("FAIL reset_handshakes: got %b want 00000",
                     {s_evhdr_tready, s_evdata_tready, m_udphdr_tvalid, m_udpdata_tvalid, err_len_o});
        end
        n_cmp++;
        if (dropped_count_o !== 16'd0) begin
            n_mis++; $display("FAIL reset_dropped: got %0d want 0", dropped_count_o);
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        n_cmp++;
        if (s_evhdr_tready !== 1'b1) begin
            n_mis++; $display("FAIL reset_idle_ready: got %b want 1", s_evhdr_tready);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_single_frag();
        bit ok;
        logic [31:0] seed;
        seed = $urandom;
        clear_all();
        stall_en = 1'b0;
        nfragment_count_i = 10'd127; event_ip_i = 32'hC0A8_0102; event_port_i = 16'd4242; event_open_i = 1'b1;
        model_event(128, 12'hABC, 127, 32'hC0A8_0102, 16'd4242, 1'b1, seed);
        send_hdr(128, 12'hABC, ok);
        @(negedge aclk);
        n_cmp++;
        if (m_udphdr_tvalid !== 1'b0) begin
            n_mis++; $display("FAIL single_hdr_early: got %b want 0 one cycle after handshake", m_udphdr_tvalid);
        end
        @(negedge aclk);
        n_cmp++;
        if (m_udphdr_tvalid !== 1'b1) begin
            n_mis++; $display("FAIL single_hdr_latency: got %b want 1 two cycles after handshake", m_udphdr_tvalid);
        end
        n_cmp++;
        if (m_udpdata_tkeep !== 8'hFF) begin
            n_mis++; $display("FAIL single_tkeep: got %h want ff", m_udpdata_tkeep);
        end
        @(posedge aclk);
        #1;
        send_data(128, seed, 128, ok);
        repeat (2) begin @(posedge aclk); #1; end
        n_cmp++;
        if (obs_hdr.size() != 1 || obs_hdr[0][15:0] !== 16'd1040) begin
            n_mis++; $display("FAIL single_udp_len: got %0d hdrs, want 1 hdr with udp_length 1040", obs_hdr.size());
        end
        n_cmp++;
        if (obs_dat.size() != exp_dat.size()) begin
            n_mis++; $display("FAIL single_beats: got %0d want %0d", obs_dat.size(), exp_dat.size());
        end
        foreach (exp_dat[i]) if (i < obs_dat.size()) begin
            n_cmp++;
            if (obs_dat[i] !== exp_dat[i]) begin
                n_mis++; $display("FAIL single_dat[%0d]: got %h want %h", i, obs_dat[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_multi_frag();
        bit ok;
        logic [31:0] seed;
        seed = $urandom;
        clear_all();
        stall_en = 1'b0;
        nfragment_count_i = 10'd3; event_ip_i = 32'h0A00_0001; event_port_i = 16'd1234; event_open_i = 1'b1;
        model_event(10, 12'h123, 3, 32'h0A00_0001, 16'd1234, 1'b1, seed);
        send_hdr(10, 12'h123, ok);
        send_data(10, seed, 10, ok);
        repeat (2) begin @(posedge aclk); #1; end
        n_cmp++;
        if (obs_hdr.size() != 3) begin
            n_mis++; $display("FAIL multi_hdr_count: got %0d want 3", obs_hdr.size());
        end
        foreach (exp_hdr[i]) if (i < obs_hdr.size()) begin
            n_cmp++;
            if (obs_hdr[i] !== exp_hdr[i]) begin
                n_mis++; $display("FAIL multi_hdr[%0d]: got %h want %h", i, obs_hdr[i], exp_hdr[i]);
            end
        end
        n_cmp++;
        if (obs_dat.size() != exp_dat.size()) begin
            n_mis++; $display("FAIL multi_beats: got %0d want %0d", obs_dat.size(), exp_dat.size());
        end
        foreach (exp_dat[i]) if (i < obs_dat.size()) begin
            n_cmp++;
            if (obs_dat[i] !== exp_dat[i]) begin
                n_mis++; $display("FAIL multi_dat[%0d]: got %h want %h", i, obs_dat[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_drop();
        bit ok;
        logic [31:0] seed;
        seed = $urandom;
        clear_all();
        stall_en = 1'b0;
        n_cmp++;
        if (dropped_count_o !== 16'(exp_drop)) begin
            n_mis++; $display("FAIL drop_before: got %0d want %0d", dropped_count_o, exp_drop);
        end
        nfragment_count_i = 10'd7; event_ip_i = 32'h0A00_0002; event_port_i = 16'd99; event_open_i = 1'b0;
        model_event(5, 12'h055, 7, 32'h0A00_0002, 16'd99, 1'b0, seed);
        send_hdr(5, 12'h055, ok);
        send_data(5, seed, 5, ok);
        repeat (2) begin @(posedge aclk); #1; end
        n_cmp++;
        if (dropped_count_o !== 16'(exp_drop)) begin
            n_mis++; $display("FAIL drop_count: got %0d want %0d", dropped_count_o, exp_drop);
        end
        n_cmp++;
        if (obs_hdr.size() != 0 || obs_dat.size() != 0 || in_beats != 5) begin
            n_mis++;
            $display("FAIL drop_traffic: got hdr=%0d dat=%0d consumed=%0d want 0/0/5",
                     obs_hdr.size(), obs_dat.size(), in_beats);
        end
        clear_all();
        seed = $urandom;
        event_open_i = 1'b1;
        model_event(1, 12'h056, 7, 32'h0A00_0002, 16'd99, 1'b1, seed);
        send_hdr(1, 12'h056, ok);
        send_data(1, seed, 1, ok);
        repeat (2) begin @(posedge aclk); #1; end
        n_cmp++;
        if (obs_hdr.size() != 1 || obs_hdr[0] !== exp_hdr[0]) begin
            n_mis++; $display("FAIL drop_reopen_hdr: got %0d hdrs, want one hdr %h (udp_length 24)",
                              obs_hdr.size(), exp_hdr[0]);
        end
        n_cmp++;
        if (obs_dat.size() != 2 || obs_dat[0] !== exp_dat[0] || obs_dat[1] !== exp_dat[1]) begin
            n_mis++; $display("FAIL drop_reopen_dat: got %0d beats, want 2 (%h %h)",
                              obs_dat.size(), exp_dat[0], exp_dat[1]);
        end
    endtask

    task automatic test_random_stall();
        bit ok;
        logic [31:0] seed;
        seed = $urandom;
        clear_all();
        stall_en = 1'b1;
        nfragment_count_i = 10'd63; event_ip_i = $urandom; event_port_i = 16'($urandom); event_open_i = 1'b1;
        model_event(300, 12'hF0F, 63, event_ip_i, event_port_i, 1'b1, seed);
        send_hdr(300, 12'hF0F, ok);
        send_data(300, seed, 300, ok);
        stall_en = 1'b0;
        repeat (3) begin @(posedge aclk); #1; end
        n_cmp++;
        if (obs_hdr.size() != 5) begin
            n_mis++; $display("FAIL stall_frag_count: got %0d want 5", obs_hdr.size());
        end
        foreach (exp_hdr[i]) if (i < obs_hdr.size()) begin
            n_cmp++;
            if (obs_hdr[i] !== exp_hdr[i]) begin
                n_mis++; $display("FAIL stall_hdr[%0d]: got %h want %h", i, obs_hdr[i], exp_hdr[i]);
            end
        end
        n_cmp++;
        if (obs_dat.size() != exp_dat.size()) begin
            n_mis++; $display("FAIL stall_beats: got %0d want %0d", obs_dat.size(), exp_dat.size());
        end
        foreach (exp_dat[i]) if (i < obs_dat.size()) begin
            n_cmp++;
            if (obs_dat[i] !== exp_dat[i]) begin
                n_mis++; $display("FAIL stall_dat[%0d]: got %h want %h", i, obs_dat[i], exp_dat[i]);
            end
        end
        n_cmp++;
        if (obs_err.size() != 0) begin
            n_mis++; $display("FAIL stall_err: got %0d pulses want 0", obs_err.size());
        end
    endtask

    task automatic test_tlast_err();
        bit ok;
        logic [31:0] seed;
        seed = $urandom;
        clear_all();
        stall_en = 1'b0;
        nfragment_count_i = 10'd7; event_ip_i = 32'h0A00_0003; event_port_i = 16'd7; event_open_i = 1'b1;
        model_event(5, 12'h333, 7, 32'h0A00_0003, 16'd7, 1'b1, seed);
        send_hdr(5, 12'h333, ok);
        send_data(5, seed, 3, ok);
        repeat (2) begin @(posedge aclk); #1; end
        n_cmp++;
        if (obs_err.size() != 2 || obs_err[0] != 3 || obs_err[1] != 5) begin
            n_mis++; $display("FAIL tlast_err_pulses: got %0d pulses (first at beat %0d), want pulses at beats 3 and 5",
                              obs_err.size(), (obs_err.size() > 0) ? obs_err[0] : -1);
        end
        n_cmp++;
        if (obs_dat.size() != exp_dat.size()) begin
            n_mis++; $display("FAIL tlast_beats: got %0d want %0d", obs_dat.size(), exp_dat.size());
        end
        foreach (exp_dat[i]) if (i < obs_dat.size()) begin
            n_cmp++;
            if (obs_dat[i] !== exp_dat[i]) begin
                n_mis++; $display("FAIL tlast_dat[%0d]: got %h want %h", i, obs_dat[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_midevent_reset();
        bit ok;
        logic [31:0] seed;
        seed = $urandom;
        clear_all();
        exp_drop = 0;
        stall_en = 1'b0;
        nfragment_count_i = 10'd3; event_ip_i = 32'h0101_0101; event_port_i = 16'd11; event_open_i = 1'b1;
        model_event(20, 12'h777, 3, 32'h0101_0101, 16'd11, 1'b1, seed);
        while (exp_hdr.size() > 2) void'(exp_hdr.pop_back());
        while (exp_dat.size() > 8) void'(exp_dat.pop_back());
        send_hdr(20, 12'h777, ok);
        nfragment_count_i = 10'd7; event_ip_i = 32'h0202_0202; event_port_i = 16'd22; event_open_i = 1'b0;
        send_data(6, seed, 0, ok);
        @(posedge aclk);
        #1;
        n_cmp++;
        if (obs_hdr.size() != 2) begin
            n_mis++; $display("FAIL midev_hdr_count: got %0d want 2", obs_hdr.size());
        end
        foreach (exp_hdr[i]) if (i < obs_hdr.size()) begin
            n_cmp++;
            if (obs_hdr[i] !== exp_hdr[i]) begin
                n_mis++; $display("FAIL midev_hdr[%0d]: got %h want %h", i, obs_hdr[i], exp_hdr[i]);
            end
        end
        n_cmp++;
        if (obs_dat.size() != 8) begin
            n_mis++; $display("FAIL midev_beats: got %0d want 8", obs_dat.size());
        end
        foreach (exp_dat[i]) if (i < obs_dat.size()) begin
            n_cmp++;
            if (obs_dat[i] !== exp_dat[i]) begin
                n_mis++; $display("FAIL midev_dat[%0d]: got %h want %h", i, obs_dat[i], exp_dat[i]);
            end
        end
        areset = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        n_cmp++;
        if ({s_evhdr_tready, s_evdata_tready, m_udphdr_tvalid, m_udpdata_tvalid, err_len_o} !== 5'b0
            || dropped_count_o !== 16'd0) begin
            n_mis++; $display("FAIL midev_reset_outputs: got %b/%0d want 00000/0",
                              {s_evhdr_tready, s_evdata_tready, m_udphdr_tvalid, m_udpdata_tvalid, err_len_o},
                              dropped_count_o);
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        n_cmp++;
        if (s_evhdr_tready !== 1'b1 || m_udphdr_tvalid !== 1'b0) begin
            n_mis++; $display("FAIL midev_idle: got rdy=%b hdr_vld=%b want 1/0", s_evhdr_tready, m_udphdr_tvalid);
        end
        @(posedge aclk);
        #1;
        clear_all();
        seed = $urandom;
        event_open_i = 1'b1;
        model_event(3, 12'h778, 7, 32'h0202_0202, 16'd22, 1'b1, seed);
        send_hdr(3, 12'h778, ok);
        send_data(3, seed, 3, ok);
        repeat (2) begin @(posedge aclk); #1; end
        n_cmp++;
        if (obs_hdr.size() != 1 || obs_hdr[0] !== exp_hdr[0]) begin
            n_mis++; $display("FAIL post_reset_hdr: got %0d hdrs, want one hdr %h", obs_hdr.size(), exp_hdr[0]);
        end
        n_cmp++;
        if (obs_dat.size() != exp_dat.size()) begin
            n_mis++; $display("FAIL post_reset_beats: got %0d want %0d", obs_dat.size(), exp_dat.size());
        end
        foreach (exp_dat[i]) if (i < obs_dat.size()) begin
            n_cmp++;
            if (obs_dat[i] !== exp_dat[i]) begin
                n_mis++; $display("FAIL post_reset_dat[%0d]: got %h want %h", i, obs_dat[i], exp_dat[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frag();
        test_multi_frag();
        test_drop();
        test_random_stall();
        test_tlast_err();
        test_midevent_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
